pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program-counter sequencer for a simple in-order core. Each cycle it picks the
// next PC (sequential, branch, JAL, JALR), stalls for data-cache accesses on
// load/store, and halts on a system opcode or a misaligned control-flow target.
//
// Ports:
//   clk         - single clock, all state updates on the rising edge
//   rst_b       - asynchronous active-low reset
//   inst_valid  - instruction fields valid; low holds the PC in RUN
//   opcode      - 7-bit opcode of the instruction at inst_addr
//   funct3      - branch condition select
//   rs1_data    - register operand 1
//   rs2_data    - register operand 2
//   imm         - sign-extended immediate (decoded externally)
//   cache_hit   - data-cache hit, only looked at in the MEM state
//   inst_addr   - registered PC
//   link_addr   - inst_addr + 4, return address for JAL/JALR writeback
//   stall       - high in MEM, MISS_WAIT, HALT, or RUN with inst_valid low
//   halted      - sticky until reset
//   misaligned  - sticky until reset; a taken target had bits [1:0] != 0
//
// Optional feature (define PC_SEQ_PERF_EN):
//   retire_cnt  - 32-bit wrapping count of PC advances and redirects
//   stall_cnt   - 32-bit wrapping count of stalled, non-halted cycles
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int                XLEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = {XLEN{1'b0}},
    parameter int                MISS_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 inst_valid,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic [XLEN-1:0]      imm,
    input  logic                 cache_hit,
    output logic [XLEN-1:0]      inst_addr,
    output logic [XLEN-1:0]      link_addr,
    output logic                 stall,
    output logic                 halted,
    output logic                 misaligned
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]          retire_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [7:0]      MISS_LOAD = 8'(MISS_WAIT);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM       = 2'd1,
        ST_MISS_WAIT = 2'd2,
        ST_HALT      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              halted_q, halted_d;
    logic              mis_q, mis_d;

    logic              taken_s;
    logic              redirect_s;
    logic [XLEN-1:0]   target_s;
    logic [XLEN-1:0]   seq_pc_s;
    logic [XLEN-1:0]   jalr_sum_s;
    logic              advance_s;
    logic              stall_s;

    // Branch condition evaluation from funct3; undefined encodings are not taken.
    always_comb begin
        taken_s = 1'b0;
        case (funct3)
            3'd0:    taken_s = (rs1_data == rs2_data);
            3'd1:    taken_s = (rs1_data != rs2_data);
            3'd4:    taken_s = ($signed(rs1_data) <  $signed(rs2_data));
            3'd5:    taken_s = ($signed(rs1_data) >= $signed(rs2_data));
            3'd6:    taken_s = (rs1_data <  rs2_data);
            3'd7:    taken_s = (rs1_data >= rs2_data);
            default: taken_s = 1'b0;
        endcase
    end

    // Control-flow target selection; all arithmetic wraps at XLEN bits.
    always_comb begin
        seq_pc_s   = pc_q + PC_STEP;
        jalr_sum_s = rs1_data + imm;
        redirect_s = 1'b0;
        target_s   = pc_q + imm;
        case (opcode)
            OP_BRANCH: redirect_s = taken_s;
            OP_JAL:    redirect_s = 1'b1;
            OP_JALR: begin
                redirect_s = 1'b1;
                target_s   = {jalr_sum_s[XLEN-1:1], 1'b0};
            end
            default:   redirect_s = 1'b0;
        endcase
    end

    // Next-state, next-PC and sticky-flag logic.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        halted_d  = halted_q;
        mis_d     = mis_q;
        advance_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (!inst_valid) begin
                    pc_d = pc_q;
                end else if (opcode == OP_SYSTEM) begin
                    halted_d = 1'b1;
                    state_d  = ST_HALT;
                end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
                    state_d = ST_MEM;
                end else if (redirect_s) begin
                    // A misaligned target never reaches the PC register.
                    if (target_s[1:0] != 2'b00) begin
                        mis_d    = 1'b1;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        pc_d      = target_s;
                        advance_s = 1'b1;
                    end
                end else begin
                    pc_d      = seq_pc_s;
                    advance_s = 1'b1;
                end
            end
            ST_MEM: begin
                if (cache_hit) begin
                    pc_d      = seq_pc_s;
                    advance_s = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    cnt_d   = MISS_LOAD;
                    state_d = ST_MISS_WAIT;
                end
            end
            ST_MISS_WAIT: begin
                // Counter enters at MISS_WAIT and leaves at 1: exactly MISS_WAIT cycles here.
                if (cnt_q <= 8'd1) begin
                    cnt_d     = 8'd0;
                    pc_d      = seq_pc_s;
                    advance_s = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State, PC, miss counter and sticky flags.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            cnt_q    <= 8'd0;
            halted_q <= 1'b0;
            mis_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            mis_q    <= mis_d;
        end
    end

    // Stall is decoded straight from the current state so the pipeline sees it this cycle.
    always_comb begin
        stall_s = 1'b1;
        if ((state_q == ST_RUN) && inst_valid) begin
            stall_s = 1'b0;
        end else begin
            stall_s = 1'b1;
        end
    end

    assign inst_addr  = pc_q;
    assign link_addr  = pc_q + PC_STEP;
    assign stall      = stall_s;
    assign halted     = halted_q;
    assign misaligned = mis_q;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] retire_q, retire_d;
    logic [31:0] stcnt_q, stcnt_d;

    // Performance counter increments.
    always_comb begin
        retire_d = retire_q;
        stcnt_d  = stcnt_q;
        if (advance_s) begin
            retire_d = retire_q + 32'd1;
        end else begin
            retire_d = retire_q;
        end
        if (stall_s && !halted_q) begin
            stcnt_d = stcnt_q + 32'd1;
        end else begin
            stcnt_d = stcnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            retire_q <= 32'd0;
            stcnt_q  <= 32'd0;
        end else begin
            retire_q <= retire_d;
            stcnt_q  <= stcnt_d;
        end
    end

    assign retire_cnt = retire_q;
    assign stall_cnt  = stcnt_q;
`else
    logic unused_advance_s;
    assign unused_advance_s = advance_s;
`endif

endmodule
